// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared UART constants and frame FSM encoding (RX and TX sides).
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_CLK_DIV_115200 = 434;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Two-flop synchroniser for the RX pad plus falling-edge detect.
// Revision : 1.0
// ============================================================================
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic meta_q, meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_dly_q, rx_dly_d;

    always_comb begin
        meta_d   = i_rx;
        rx_s_d   = meta_q;
        rx_dly_d = rx_s_q;
    end

    // Flops reset high so a reset never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            meta_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_dly_q <= 1'b1;
        end else begin
            meta_q   <= meta_d;
            rx_s_q   <= rx_s_d;
            rx_dly_q <= rx_dly_d;
        end
    end

    assign o_rx_s = rx_s_q;
    assign o_fall = rx_dly_q & ~rx_s_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, mid-bit sampling, valid/ready byte handoff.
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int CLK_DIV   = UART_CLK_DIV_115200,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_HALF = WIDTH'(CLK_DIV >> 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic rx_s;
    logic fall;
    logic tick;

    uart_state_e          state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 deliver_q, deliver_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_rx_sync u_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_rx   (i_rx),
        .o_rx_s (rx_s),
        .o_fall (fall)
    );

    assign tick = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + WIDTH'(1);
        end

        case (state_q)
            // Preloading half a bit makes every later tick land mid-bit.
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        deliver_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh byte replaces the held one only if the sink is taking it now.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!valid_q || i_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            deliver_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx; byte scoreboard plus pulse counts.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int FAST_DIV = 16;
    localparam int SLOW_DIV = 434;

    logic       clk = 1'b0;
    logic       nrst;
    logic       line_f, line_s;
    logic       ready;
    logic [7:0] data_f, data_s;
    logic       valid_f, valid_s, busy_f, busy_s;
    logic       ferr_f, ferr_s, ovr_f, ovr_s;

    always #5 clk = ~clk;

    uart_rx #(.WIDTH(5), .CLK_DIV(FAST_DIV), .DATA_BITS(8)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_rx        (line_f),
        .o_data      (data_f),
        .o_valid     (valid_f),
        .i_ready     (ready),
        .o_busy      (busy_f),
        .o_frame_err (ferr_f),
        .o_overrun   (ovr_f)
    );

    uart_rx #(.WIDTH(9), .CLK_DIV(SLOW_DIV), .DATA_BITS(8)) dut_slow (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_rx        (line_s),
        .o_data      (data_s),
        .o_valid     (valid_s),
        .i_ready     (ready),
        .o_busy      (busy_s),
        .o_frame_err (ferr_s),
        .o_overrun   (ovr_s)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         first_valid_cyc = 0;
    int         n_valid_cyc = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_err_s = 0;
    logic       prev_valid_f = 1'b0;
    logic [7:0] got_f[$];
    logic [7:0] got_s[$];

    // Observes outputs mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_valid_f <= valid_f;
        if (valid_f && !prev_valid_f) first_valid_cyc <= cyc + 1;
        if (valid_f) n_valid_cyc <= n_valid_cyc + 1;
        if (valid_f && ready) got_f.push_back(data_f);
        if (ferr_f) n_ferr <= n_ferr + 1;
        if (ovr_f) n_ovr <= n_ovr + 1;
        if (valid_s && ready) got_s.push_back(data_s);
        if (ferr_s || ovr_s) n_err_s <= n_err_s + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit slow, input logic v);
        if (slow) line_s = v;
        else      line_f = v;
    endtask

    // Leaves the line at the stop-bit level; caller restores idle if needed.
    task automatic send_byte(input bit slow, input logic [7:0] b, input int period,
                             input logic stop_v);
        drive(slow, 1'b0);
        start_cyc = cyc;
        tick_clk(period);
        for (int i = 0; i < 8; i++) begin
            drive(slow, b[i]);
            tick_clk(period);
        end
        drive(slow, stop_v);
        tick_clk(period);
    endtask

    function automatic logic [7:0] q_at(input logic [7:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 8'hxx;
    endfunction

    initial begin
        int         base_ferr, base_ovr, base_valid, lat, exp_ferr;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        nrst = 1'b0; line_f = 1'b1; line_s = 1'b1; ready = 1'b1;
        tick_clk(3);
        check_eq("rst_fast_outs", 32'({data_f, valid_f, busy_f, ferr_f, ovr_f}), 32'd0);
        check_eq("rst_slow_outs", 32'({data_s, valid_s, busy_s, ferr_s, ovr_s}), 32'd0);
        nrst = 1'b1;
        tick_clk(5);

        // Single byte, sink always ready.
        got_f.delete();
        base_ferr = n_ferr; base_ovr = n_ovr; base_valid = n_valid_cyc;
        send_byte(0, 8'hA5, FAST_DIV, 1'b1);
        tick_clk(24);
        lat = first_valid_cyc - start_cyc;
        check_eq("t1_count", 32'(got_f.size()), 32'd1);
        check_eq("t1_data", 32'(q_at(got_f, 0)), 32'hA5);
        check_eq("t1_latency_window", 32'(lat >= 144 && lat <= 170), 32'd1);
        check_eq("t1_valid_cycles", 32'(n_valid_cyc - base_valid), 32'd1);
        check_eq("t1_no_flags", 32'((n_ferr - base_ferr) + (n_ovr - base_ovr)), 32'd0);

        // Back-to-back bytes into a stalled sink.
        ready = 1'b0;
        got_f.delete();
        base_ovr = n_ovr;
        send_byte(0, 8'h3C, FAST_DIV, 1'b1);
        send_byte(0, 8'hC3, FAST_DIV, 1'b1);
        tick_clk(32);
        check_eq("t2_valid_held", 32'(valid_f), 32'd1);
        check_eq("t2_data_held", 32'(data_f), 32'h3C);
        check_eq("t2_overrun_once", 32'(n_ovr - base_ovr), 32'd1);
        ready = 1'b1;
        tick_clk(3);
        check_eq("t2_drain_count", 32'(got_f.size()), 32'd1);
        check_eq("t2_drain_data", 32'(q_at(got_f, 0)), 32'h3C);
        check_eq("t2_valid_cleared", 32'(valid_f), 32'd0);

        // Low stop bit followed by a long break.
        got_f.delete();
        base_ferr = n_ferr;
        send_byte(0, 8'h55, FAST_DIV, 1'b0);
        check_eq("t3_ferr_once", 32'(n_ferr - base_ferr), 32'd1);
        tick_clk(40 * FAST_DIV);
        check_eq("t3_break_ferr", 32'(n_ferr - base_ferr), 32'd1);
        check_eq("t3_break_busy", 32'(busy_f), 32'd0);
        check_eq("t3_no_byte", 32'(got_f.size()), 32'd0);
        line_f = 1'b1;
        tick_clk(2 * FAST_DIV);
        check_eq("t3_recover_ferr", 32'(n_ferr - base_ferr), 32'd1);
        check_eq("t3_valid_low", 32'(valid_f), 32'd0);

        // Short low glitch on an idle line.
        base_ferr = n_ferr; base_ovr = n_ovr;
        line_f = 1'b0;
        tick_clk(4);
        line_f = 1'b1;
        tick_clk(1);
        check_eq("t4_glitch_busy", 32'(busy_f), 32'd1);
        tick_clk(3 * FAST_DIV);
        check_eq("t4_back_idle", 32'(busy_f), 32'd0);
        check_eq("t4_no_byte", 32'(got_f.size()), 32'd0);
        check_eq("t4_no_flags", 32'((n_ferr - base_ferr) + (n_ovr - base_ovr)), 32'd0);

        // Reset in the middle of data bit 4.
        b = 8'h6B;
        line_f = 1'b0;
        tick_clk(FAST_DIV);
        for (int i = 0; i < 4; i++) begin
            line_f = b[i];
            tick_clk(FAST_DIV);
        end
        line_f = b[4];
        tick_clk(FAST_DIV / 2);
        check_eq("t5_busy_before", 32'(busy_f), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        check_eq("t5_outs_zero", 32'({data_f, valid_f, busy_f, ferr_f, ovr_f}), 32'd0);
        line_f = 1'b1;
        tick_clk(3);
        nrst = 1'b1;
        tick_clk(4);
        got_f.delete();
        send_byte(0, 8'h81, FAST_DIV, 1'b1);
        tick_clk(24);
        check_eq("t5_count", 32'(got_f.size()), 32'd1);
        check_eq("t5_data", 32'(q_at(got_f, 0)), 32'h81);

        // Random frames, some with a broken stop bit, checked against a scoreboard.
        got_f.delete();
        base_ferr = n_ferr; base_ovr = n_ovr;
        exp_ferr = 0;
        for (int k = 0; k < 12; k++) begin
            logic bad;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_byte(0, b, FAST_DIV, !bad);
            if (bad) exp_ferr++;
            else     exp_q.push_back(b);
            line_f = 1'b1;
            tick_clk(FAST_DIV * $urandom_range(1, 3));
        end
        tick_clk(2 * FAST_DIV);
        check_eq("rnd_count", 32'(got_f.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check_eq($sformatf("rnd_byte%0d", k), 32'(q_at(got_f, k)), 32'(exp_q[k]));
        end
        check_eq("rnd_ferr", 32'(n_ferr - base_ferr), 32'(exp_ferr));
        check_eq("rnd_ovr", 32'(n_ovr - base_ovr), 32'd0);

        // Baud mismatch of about +-3% on the 115200 configuration.
        got_s.delete();
        send_byte(1, 8'h00, 421, 1'b1);
        tick_clk(SLOW_DIV);
        send_byte(1, 8'hFF, 447, 1'b1);
        tick_clk(SLOW_DIV);
        send_byte(1, 8'hFF, 421, 1'b1);
        tick_clk(SLOW_DIV);
        send_byte(1, 8'h00, 447, 1'b1);
        tick_clk(SLOW_DIV);
        check_eq("baud_count", 32'(got_s.size()), 32'd4);
        check_eq("baud_00_fast", 32'(q_at(got_s, 0)), 32'h00);
        check_eq("baud_ff_slow", 32'(q_at(got_s, 1)), 32'hFF);
        check_eq("baud_ff_fast", 32'(q_at(got_s, 2)), 32'hFF);
        check_eq("baud_00_slow", 32'(q_at(got_s, 3)), 32'h00);
        check_eq("baud_no_flags", 32'(n_err_s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
